lcd_msg_scheduler: RTL and testbench
====================================

Name: lcd_msg_scheduler

Overview:
- Arbitrates between several requesters (mode logic, menu, tracking status) that want a message shown on the 16x2 LCD.
- Drives the 4-bit message selector consumed by the LCD top level.
- Guarantees a minimum on-screen hold time per message.
- Reverts to an idle/banner message after a timeout with no new requests.
- Sits between the control FSMs and the LCD top level, in the iCLK (50 MHz) domain.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- MSG_W, 4: message selector width.
- HOLD_CYCLES, 50_000_000: minimum cycles a granted message stays displayed (≥1).
- TIMEOUT_CYCLES, 250_000_000: cycles after a grant before reverting to IDLE_MSG (> HOLD_CYCLES).
- IDLE_MSG, 0: selector value shown after reset and after timeout.
- CNT_W, 28: hold/timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- iCLK  in  1  system clock, 50 MHz.
- iRST_N  in  1  asynchronous active-low reset.
- iREQ  in  NUM_REQ  level request per requester; bit k = requester k.
- iREQ_MSG  in  NUM_REQ*MSG_W  requested selector; slice [k*MSG_W +: MSG_W] belongs to requester k.
- oGNT  out  NUM_REQ  one-cycle grant pulse, at most one bit set.
- oMENSAJE  out  MSG_W  registered message selector to the LCD top.
- oOWNER  out  3  index of the current owner; valid only when oOWNER_VLD=1.
- oOWNER_VLD  out  1  1 while a granted message, not IDLE_MSG, is displayed.
- oBUSY  out  1  1 while in HOLD, i.e. requests cannot be granted yet.

Behaviour:
- Reset (asynchronous, iRST_N=0) forces:
  - oMENSAJE=IDLE_MSG, oGNT=0, oOWNER=0, oOWNER_VLD=0, oBUSY=0.
  - state=IDLE, counter=0, round-robin pointer=0.
- Reset asserted mid-operation aborts immediately to these values; there is no pending-grant memory.
- State IDLE:
  - On any edge where iREQ≠0, grant the winner on that same edge.
  - Effects of the grant: oGNT[w]=1 for one cycle; oMENSAJE=iREQ_MSG slice w, sampled at that edge; oOWNER=w; oOWNER_VLD=1; counter=0; state=HOLD; pointer=(w+1) mod NUM_REQ.
  - Latency from request to grant: 1 edge.
- Arbitration: round-robin.
  - Search starts at the pointer and proceeds upward with wrap-around.
  - The first set bit wins.
  - Simultaneous requests are resolved by this rule only.
- State HOLD (oBUSY=1):
  - Counter increments every cycle.
  - Requests are not granted; they stay pending as long as iREQ remains high.
  - On the edge where counter==HOLD_CYCLES-1:
    - If iREQ≠0, grant as above (counter=0, stay HOLD). Back-to-back grants are therefore spaced exactly HOLD_CYCLES cycles.
    - Otherwise go to OPEN and keep counting.
- State OPEN (oBUSY=0):
  - Counter keeps incrementing.
  - Any iREQ≠0 is granted on that edge, with counter=0 and state=HOLD.
  - If counter==TIMEOUT_CYCLES-1 with no request: oMENSAJE=IDLE_MSG, oOWNER_VLD=0, state=IDLE, counter=0.
  - Request and timeout on the same edge: the grant wins.
- Requester contract:
  - Deassert iREQ within one cycle after seeing its oGNT bit.
  - A still-high iREQ is treated as a new request and re-arbitrated fairly.
- A requested value equal to IDLE_MSG is shown normally and counts as owned.
- The message is captured only at grant; later changes to iREQ_MSG do not alter oMENSAJE.
- oMENSAJE changes only on grant or timeout edges, so the LCD never sees glitches.

Test Plan:
Bench parameters for all scenarios: HOLD_CYCLES=4, TIMEOUT_CYCLES=10, NUM_REQ=4.
1. Reset release, no requests for 20 cycles -> oMENSAJE=0, oOWNER_VLD=0, oGNT=0 throughout.
2. iREQ=0010 with msg1=2 pulsed for one cycle in IDLE -> next edge: oGNT=0010, oMENSAJE=2, oOWNER=1, oBUSY=1 for 4 cycles; oMENSAJE returns to 0 exactly 10 cycles after the grant.
3. iREQ=1111 held high with msgs 0,1,2,3 -> grants to requesters 0,1,2,3,0 in turn, each exactly 4 cycles apart, with oMENSAJE following 0,1,2,3,0.
4. Grant to requester 2, then requester 0 requests at counter=1 -> no grant during HOLD; grant at the edge where counter==3; oMENSAJE switches 4 cycles after the first grant.
5. Requester 3 request arrives on the same edge as the timeout (counter==9) -> grant to 3 is issued and the revert to IDLE_MSG does not occur.
6. iRST_N pulsed low mid-HOLD -> outputs go to reset values immediately; after release, a pending iREQ=0100 is granted on the first edge, with the pointer reset to 0.

Source files
------------

// File: rtl/lcd_msg_scheduler.sv
// Round-robin arbiter for LCD message requests. A granted message is held on screen
// for a minimum time, and the display falls back to the idle banner if no new request arrives.
module lcd_msg_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int MSG_W          = 4,
  parameter int HOLD_CYCLES    = 50_000_000,
  parameter int TIMEOUT_CYCLES = 250_000_000,
  parameter int IDLE_MSG       = 0,
  parameter int CNT_W          = 28
) (
  input  logic                     iCLK,
  input  logic                     iRST_N,
  input  logic [NUM_REQ-1:0]       iREQ,
  input  logic [NUM_REQ*MSG_W-1:0] iREQ_MSG,
  output logic [NUM_REQ-1:0]       oGNT,
  output logic [MSG_W-1:0]         oMENSAJE,
  output logic [2:0]               oOWNER,
  output logic                     oOWNER_VLD,
  output logic                     oBUSY
);

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]       LAST_REQ     = 3'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_OPEN
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       ptr;

  logic             win_vld;
  logic [2:0]       win_idx;
  logic             do_grant;
  logic [MSG_W-1:0] win_msg;

  // Lowest set bit at or above the pointer wins; if none, the lowest set bit overall (wrap-around).
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (iREQ[j]) begin
        win_vld = 1'b1;
        win_idx = 3'(j);
      end
    end
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (iREQ[j] && (j >= int'(ptr))) begin
        win_idx = 3'(j);
      end
    end
  end

  always_comb begin
    do_grant = 1'b0;
    case (state)
      ST_IDLE: do_grant = win_vld;
      ST_HOLD: do_grant = win_vld && (cnt == HOLD_LAST);
      ST_OPEN: do_grant = win_vld;
      default: do_grant = 1'b0;
    endcase
  end

  assign win_msg = iREQ_MSG[int'(win_idx)*MSG_W +: MSG_W];

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      ptr        <= '0;
      oGNT       <= '0;
      oMENSAJE   <= MSG_W'(IDLE_MSG);
      oOWNER     <= '0;
      oOWNER_VLD <= 1'b0;
      oBUSY      <= 1'b0;
    end else begin
      oGNT <= '0;
      if (do_grant) begin
        state      <= ST_HOLD;
        cnt        <= '0;
        ptr        <= (win_idx == LAST_REQ) ? 3'd0 : win_idx + 3'd1;
        oGNT       <= NUM_REQ'(1) << win_idx;
        oMENSAJE   <= win_msg;
        oOWNER     <= win_idx;
        oOWNER_VLD <= 1'b1;
        oBUSY      <= 1'b1;
      end else begin
        case (state)
          ST_HOLD: begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == HOLD_LAST) begin
              state <= ST_OPEN;
              oBUSY <= 1'b0;
            end
          end
          ST_OPEN: begin
            if (cnt == TIMEOUT_LAST) begin
              state      <= ST_IDLE;
              cnt        <= '0;
              oMENSAJE   <= MSG_W'(IDLE_MSG);
              oOWNER_VLD <= 1'b0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          ST_IDLE: cnt <= '0;
          default: begin
            state <= ST_IDLE;
            cnt   <= '0;
            oBUSY <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lcd_msg_scheduler.sv
// Scoreboard bench for lcd_msg_scheduler: a timestamp-based reference model predicts each cycle's
// outputs and every grant, and a monitor process compares them against the DUT.
module tb_lcd_msg_scheduler;
  localparam int N       = 4;
  localparam int MW      = 4;
  localparam int HOLD    = 4;
  localparam int TIMEOUT = 10;
  localparam int IDLE    = 0;

  logic          iCLK = 1'b0;
  logic          iRST_N = 1'b0;
  logic [N-1:0]  iREQ = '0;
  logic [N*MW-1:0] iREQ_MSG = '0;
  logic [N-1:0]  oGNT;
  logic [MW-1:0] oMENSAJE;
  logic [2:0]    oOWNER;
  logic          oOWNER_VLD;
  logic          oBUSY;

  lcd_msg_scheduler #(
    .NUM_REQ(N), .MSG_W(MW), .HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TIMEOUT),
    .IDLE_MSG(IDLE), .CNT_W(8)
  ) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iREQ(iREQ), .iREQ_MSG(iREQ_MSG),
    .oGNT(oGNT), .oMENSAJE(oMENSAJE), .oOWNER(oOWNER), .oOWNER_VLD(oOWNER_VLD), .oBUSY(oBUSY)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    logic [N-1:0]  gnt;
    logic [MW-1:0] msg;
    logic [2:0]    owner;
    logic          vld;
    logic          busy;
    logic          own_chk;
  } st_t;
  typedef struct {
    int idx;
    int msg;
  } g_t;

  st_t sq[$];
  g_t  gq[$];
  int  total = 0;
  int  bad = 0;

  // reference model: grants remembered by the cycle number at which they happened
  int  m_cyc = 0;
  int  m_last = 0;
  bit  m_active = 0;
  int  m_msg = IDLE;
  int  m_owner = 0;
  int  m_ptr = 0;
  bit  m_gnt_now = 0;
  int  m_gnt_idx = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_step();
    int elapsed;
    st_t s;
    m_cyc++;
    m_gnt_now = 0;
    if (!iRST_N) begin
      m_active = 0;
      m_msg    = IDLE;
      m_owner  = 0;
      m_ptr    = 0;
    end else begin
      elapsed = m_cyc - m_last;
      if (iREQ != 0 && (!m_active || elapsed >= HOLD)) begin
        for (int k = 0; k < N; k++) begin
          if (iREQ[(m_ptr + k) % N]) begin
            m_gnt_idx = (m_ptr + k) % N;
            break;
          end
        end
        m_gnt_now = 1;
        m_msg     = int'(iREQ_MSG[m_gnt_idx*MW +: MW]);
        m_owner   = m_gnt_idx;
        m_active  = 1;
        m_last    = m_cyc;
        m_ptr     = (m_gnt_idx + 1) % N;
        gq.push_back('{m_gnt_idx, m_msg});
      end else if (m_active && elapsed >= TIMEOUT) begin
        m_active = 0;
        m_msg    = IDLE;
      end
    end
    s.gnt     = m_gnt_now ? N'(1) << m_gnt_idx : '0;
    s.msg     = MW'(m_msg);
    s.owner   = 3'(m_owner);
    s.vld     = m_active;
    s.busy    = m_active && ((m_cyc - m_last) < HOLD);
    s.own_chk = m_active || !iRST_N;
    sq.push_back(s);
  endtask

  task automatic cyc(input logic rst, input logic [N-1:0] req, input logic [N*MW-1:0] msgs);
    @(negedge iCLK);
    iRST_N   = rst;
    iREQ     = req;
    iREQ_MSG = msgs;
    model_step();
  endtask

  task automatic quiet(input int n);
    for (int k = 0; k < n; k++) cyc(1'b1, '0, N*MW'($urandom));
  endtask

  // monitor: per-cycle status plus grant scoreboard
  always @(posedge iCLK) begin
    st_t e;
    g_t  g;
    int  a;
    #1;
    if (sq.size() > 0) begin
      e = sq.pop_front();
      check("gnt", 32'(oGNT), 32'(e.gnt));
      check("mensaje", 32'(oMENSAJE), 32'(e.msg));
      check("owner_vld", 32'(oOWNER_VLD), 32'(e.vld));
      check("busy", 32'(oBUSY), 32'(e.busy));
      if (e.own_chk) check("owner", 32'(oOWNER), 32'(e.owner));
    end
    if (oGNT != '0) begin
      a = 0;
      for (int k = 0; k < N; k++) if (oGNT[k]) a = k;
      check("gnt_onehot", 32'($countones(oGNT)), 32'd1);
      if (gq.size() == 0) begin
        check("gnt_unexpected", 32'(oGNT), 32'd0);
      end else begin
        g = gq.pop_front();
        check("gnt_idx", 32'(a), 32'(g.idx));
        check("gnt_msg", 32'(oMENSAJE), 32'(g.msg));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not complete, got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dens;
    // 1: reset, then idle for 20 cycles
    cyc(1'b0, '0, '0);
    cyc(1'b0, '0, '0);
    quiet(20);
    // 2: single pulse from requester 1, then timeout back to idle banner
    cyc(1'b1, 4'b0010, 16'h0020);
    quiet(12);
    // 3: all four held high, starting from a fresh pointer
    cyc(1'b0, '0, '0);
    for (int k = 0; k < 17; k++) cyc(1'b1, 4'b1111, 16'h3210);
    quiet(12);
    // 4: requester 0 arrives during requester 2's hold
    cyc(1'b1, 4'b0100, 16'h0900);
    cyc(1'b1, 4'b0000, 16'h0900);
    for (int k = 0; k < 10; k++) begin
      cyc(1'b1, 4'b0001, 16'h000C);
      if (m_gnt_now) break;
    end
    quiet(12);
    // 5: request coincides with the timeout edge
    cyc(1'b1, 4'b0001, 16'h0005);
    quiet(9);
    cyc(1'b1, 4'b1000, 16'h7000);
    quiet(12);
    // 6: reset mid-hold, pending request granted right after release
    cyc(1'b1, 4'b0001, 16'h0003);
    quiet(2);
    cyc(1'b0, 4'b0100, 16'h0B00);
    #1;
    check("async_rst_msg", 32'(oMENSAJE), 32'(IDLE));
    check("async_rst_vld", 32'(oOWNER_VLD), 32'd0);
    check("async_rst_busy", 32'(oBUSY), 32'd0);
    check("async_rst_gnt", 32'(oGNT), 32'd0);
    check("async_rst_owner", 32'(oOWNER), 32'd0);
    cyc(1'b1, 4'b0100, 16'h0B00);
    cyc(1'b1, 4'b0000, 16'h0B00);
    // pointer is now 3; after reset, 1100 must go to requester 2
    cyc(1'b0, 4'b1100, 16'h45AA);
    cyc(1'b1, 4'b1100, 16'h45AA);
    quiet(14);
    // random phase with varying request density and rare resets
    for (int b = 0; b < 12; b++) begin
      dens = (b % 3 == 0) ? 3 : ((b % 3 == 1) ? 30 : 75);
      for (int k = 0; k < 100; k++) begin
        cyc(($urandom_range(0, 199) != 0),
            ($urandom_range(0, 99) < dens) ? N'($urandom_range(1, 15)) : '0,
            N*MW'($urandom));
      end
    end
    quiet(3);
    @(posedge iCLK);
    #2;
    check("status_queue_drained", 32'(sq.size()), 32'd0);
    check("grant_queue_drained", 32'(gq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
